// File: rtl/cold_storage_pkg.sv
// Shared ASCII constants, parser state type and byte classifiers for the
// UART command parser.
package cold_storage_pkg;

  localparam logic [7:0] ASC_L  = 8'h4C;
  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_B  = 8'h42;
  localparam logic [7:0] ASC_C  = 8'h43;
  localparam logic [7:0] ASC_D  = 8'h44;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_9  = 8'h39;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  localparam int TIMEOUT_CYCLES_DEF = 1_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GOT_CMD = 2'd1,
    GOT_V0  = 2'd2,
    GOT_V1  = 2'd3
  } parser_state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == ASC_L) || (b >= ASC_A && b <= ASC_D);
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_9);
  endfunction

  function automatic logic is_term(input logic [7:0] b);
    return (b == ASC_CR) || (b == ASC_LF);
  endfunction

endpackage

// File: rtl/cmd_idle_timer.sv
// Inter-byte idle counter: counts cycles while active and not restarted,
// expire is high on the CYCLES-th consecutive idle cycle.
module cmd_idle_timer #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic restart,
  output logic expire
);

  localparam int W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  // Holds at LAST; the parser leaves the active states on expiry, which clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (restart || !active) cnt <= '0;
    else if (cnt != LAST)        cnt <= cnt + 1'b1;
  end

  assign expire = active && !restart && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses <cmd><digit><digit><CR|LF> frames from a UART byte stream.
// Optional inter-byte timeout compiled in with CMD_PARSER_TIMEOUT_EN.
module uart_cmd_parser
  import cold_storage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] chr_cmd,
  output logic [7:0] chr_val0,
  output logic [7:0] chr_val1,
  output logic       rx_msg_done,
  output logic       frame_err,
  output logic [7:0] err_count
);

  // Async assert, clk-synchronous release.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  parser_state_t state;
  logic [7:0]    sh_cmd, sh_v0, sh_v1;
  logic          timeout_hit;
  logic          byte_ok;
  logic          reject;

`ifdef CMD_PARSER_TIMEOUT_EN
  cmd_idle_timer #(.CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_int_n),
    .active  (state != IDLE),
    .restart (rx_valid),
    .expire  (timeout_hit)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    byte_ok = 1'b1;
    case (state)
      GOT_CMD, GOT_V0: byte_ok = is_digit(rx_byte);
      GOT_V1:          byte_ok = is_term(rx_byte);
      default:         byte_ok = 1'b1;
    endcase
  end

  // A timeout can only win on cycles without a byte; the timer is gated by rx_valid.
  assign reject = rx_valid ? ((state != IDLE) && !byte_ok) : timeout_hit;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= IDLE;
      sh_cmd      <= '0;
      sh_v0       <= '0;
      sh_v1       <= '0;
      chr_cmd     <= '0;
      chr_val0    <= '0;
      chr_val1    <= '0;
      rx_msg_done <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      frame_err <= 1'b0;
      if (reject) begin
        frame_err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        sh_v0 <= '0;
        sh_v1 <= '0;
        // Resync: an offending cmd byte starts a fresh frame.
        if (rx_valid && is_cmd(rx_byte)) begin
          sh_cmd      <= rx_byte;
          state       <= GOT_CMD;
          rx_msg_done <= 1'b0;
        end else begin
          sh_cmd <= '0;
          state  <= IDLE;
        end
      end else if (rx_valid) begin
        case (state)
          IDLE: if (is_cmd(rx_byte)) begin
            sh_cmd      <= rx_byte;
            state       <= GOT_CMD;
            rx_msg_done <= 1'b0;
          end
          GOT_CMD: begin
            sh_v0 <= rx_byte;
            state <= GOT_V0;
          end
          GOT_V0: begin
            sh_v1 <= rx_byte;
            state <= GOT_V1;
          end
          GOT_V1: begin
            chr_cmd     <= sh_cmd;
            chr_val0    <= sh_v0;
            chr_val1    <= sh_v1;
            rx_msg_done <= 1'b1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser; timeout scenario follows CMD_PARSER_TIMEOUT_EN.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] chr_cmd, chr_val0, chr_val1, err_count;
  logic       rx_msg_done, frame_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_cmd_parser #(.TIMEOUT_CYCLES(100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .chr_cmd     (chr_cmd),
    .chr_val0    (chr_val0),
    .chr_val1    (chr_val1),
    .rx_msg_done (rx_msg_done),
    .frame_err   (frame_err),
    .err_count   (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns at the negedge after the capturing posedge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic chk_chr(input string tag, input logic [7:0] c, input logic [7:0] v0,
                         input logic [7:0] v1);
    chk({tag, "_cmd"}, {24'd0, chr_cmd}, {24'd0, c});
    chk({tag, "_v0"},  {24'd0, chr_val0}, {24'd0, v0});
    chk({tag, "_v1"},  {24'd0, chr_val1}, {24'd0, v1});
  endtask

  initial begin
    int exp_err;
    int hit_at;
    rst_n    = 1'b0;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_chr("reset", 8'h00, 8'h00, 8'h00);
    chk("reset_done", {31'd0, rx_msg_done}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_errc", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Non-cmd byte in IDLE is ignored silently
    send(8'h45);
    chk("idle_E_ferr", {31'd0, frame_err}, 32'd0);
    chk("idle_E_errc", {24'd0, err_count}, 32'd0);

    // A 1 8 LF
    send("A"); send("1"); send("8");
    chk("a18_pre_done", {31'd0, rx_msg_done}, 32'd0);
    chk("a18_pre_cmd", {24'd0, chr_cmd}, 32'h00);
    send(8'h0A);
    chk_chr("a18", 8'h41, 8'h31, 8'h38);
    chk("a18_done", {31'd0, rx_msg_done}, 32'd1);

    // D 3 x CR
    send("D"); send("3"); send("x");
    chk("d3x_ferr", {31'd0, frame_err}, 32'd1);
    chk("d3x_errc", {24'd0, err_count}, 32'd1);
    chk_chr("d3x", 8'h41, 8'h31, 8'h38);
    @(negedge clk);
    chk("d3x_ferr_pulse", {31'd0, frame_err}, 32'd0);
    send(8'h0D);
    chk("d3x_cr_ferr", {31'd0, frame_err}, 32'd0);
    chk("d3x_cr_errc", {24'd0, err_count}, 32'd1);

    // B 4 C 2 5 CR: resync on C
    send("B");
    chk("b4_done_clr", {31'd0, rx_msg_done}, 32'd0);
    send("4"); send("C");
    chk("resync_ferr", {31'd0, frame_err}, 32'd1);
    chk("resync_errc", {24'd0, err_count}, 32'd2);
    send("2"); send("5");
    chk("resync_pre_cmd", {24'd0, chr_cmd}, 32'h41);
    send(8'h0D);
    chk_chr("resync", 8'h43, 8'h32, 8'h35);
    chk("resync_done", {31'd0, rx_msg_done}, 32'd1);

    // L 1 0 CR, then CR LF, then C
    send("L"); send("1"); send("0"); send(8'h0D);
    chk_chr("l10", 8'h4C, 8'h31, 8'h30);
    send(8'h0D); send(8'h0A);
    chk("crlf_done", {31'd0, rx_msg_done}, 32'd1);
    send("C");
    chk("c_done_clr", {31'd0, rx_msg_done}, 32'd0);
    chk_chr("c_keep", 8'h4C, 8'h31, 8'h30);

    // A in GOT_CMD -> error + resync, then 1, then 150 idle cycles
    send("A");
    chk("a_resync_ferr", {31'd0, frame_err}, 32'd1);
    exp_err = 3;
    chk("a_resync_errc", {24'd0, err_count}, exp_err);
    send("1");
    hit_at = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (frame_err === 1'b1 && hit_at == 0) hit_at = i;
    end
`ifdef CMD_PARSER_TIMEOUT_EN
    exp_err = 4;
    chk("timeout_cycle", hit_at, 32'd100);
    chk("timeout_errc", {24'd0, err_count}, exp_err);
    send("9"); send(8'h0A);
    chk("timeout_no_commit", {31'd0, rx_msg_done}, 32'd0);
    chk_chr("timeout_keep", 8'h4C, 8'h31, 8'h30);
`else
    chk("notimeout_no_err", hit_at, 32'd0);
    send("9"); send(8'h0A);
    chk("notimeout_commit", {31'd0, rx_msg_done}, 32'd1);
    chk_chr("notimeout", 8'h41, 8'h31, 8'h39);
`endif
    chk("post_idle_errc", {24'd0, err_count}, exp_err);

    // 260 bad frames: A followed by a just-out-of-range digit
    for (int i = 0; i < 260; i++) begin
      send("A");
      send((i % 2 == 0) ? 8'h3A : 8'h2F);
      if (i == 0) chk("bad_first_errc", {24'd0, err_count}, exp_err + 1);
      if (i == 259) chk("bad_last_ferr", {31'd0, frame_err}, 32'd1);
    end
    chk("sat_errc", {24'd0, err_count}, 32'd255);

    // Reset mid-frame
    send("A"); send("2");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_errc", {24'd0, err_count}, 32'd0);
    chk("rst_done", {31'd0, rx_msg_done}, 32'd0);
    chk_chr("rst", 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send("3"); send(8'h0A);
    chk("post_rst_done", {31'd0, rx_msg_done}, 32'd0);
    chk("post_rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("post_rst_errc", {24'd0, err_count}, 32'd0);
    chk_chr("post_rst", 8'h00, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1_000_000, sets inter-byte timeout in clk cycles (10 ms at 100 MHz).
REQ-002 clk  input  1  system clock (100 MHz); the block SHALL use this single clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx_byte  input  8  received UART byte, valid only while rx_valid=1.
REQ-005 rx_valid  input  1  one-cycle strobe from UART receiver, at most one per cycle.
REQ-006 chr_cmd  output  8  ASCII command of last committed frame.
REQ-007 chr_val0  output  8  ASCII tens digit of last committed frame.
REQ-008 chr_val1  output  8  ASCII units digit of last committed frame.
REQ-009 rx_msg_done  output  1  level; high while committed frame is current.
REQ-010 frame_err  output  1  one-cycle pulse on any rejected frame.
REQ-011 err_count  output  8  count of rejected frames, saturating at 255.

Function
REQ-012 Frame SHALL be: cmd byte in {'L'(0x4C),'A','B','C','D'(0x41-0x44)}, two digits '0'-'9' (0x30-0x39), terminator CR (0x0D) or LF (0x0A).
REQ-013 FSM states SHALL be IDLE, GOT_CMD, GOT_V0, GOT_V1; state advances only on cycles with rx_valid=1.
REQ-014 IDLE: valid cmd -> latch into shadow register, GOT_CMD; any other byte ignored silently, no error (absorbs stray CR/LF, CRLF pairs).
REQ-015 GOT_CMD: digit -> shadow val0, GOT_V0; GOT_V0: digit -> shadow val1, GOT_V1.
REQ-016 GOT_V1: CR or LF -> commit, IDLE.
REQ-017 Any unexpected byte in GOT_CMD/GOT_V0/GOT_V1 SHALL pulse frame_err, increment err_count, and discard shadow contents.
REQ-018 Resync: if the unexpected byte is itself a valid cmd, next state SHALL be GOT_CMD with that cmd latched; otherwise IDLE.
REQ-019 Commit SHALL update chr_cmd, chr_val0, chr_val1 atomically and set rx_msg_done=1 on the clock edge after the terminator strobe (1-cycle latency).
REQ-020 Outputs chr_* SHALL change only at commit; partial frames never appear on them.
REQ-021 rx_msg_done SHALL stay high until the first cmd byte of a later frame is accepted, then clear on the next edge; it SHALL remain high across ignored bytes and errors.
REQ-022 Commit and frame_err SHALL never occur in the same cycle.
REQ-023 err_count at 255 SHALL hold at 255; frame_err still pulses.
REQ-024 Inter-byte timeout: in GOT_CMD/GOT_V0/GOT_V1, if TIMEOUT_CYCLES cycles elapse with no rx_valid, the block SHALL pulse frame_err, increment err_count, return to IDLE; counter restarts on every rx_valid.
REQ-025 Timeout expiry coinciding with rx_valid SHALL be ignored; the byte is processed normally.

Reset
REQ-026 On rst_n=0 (asynchronous), state=IDLE, chr_cmd=chr_val0=chr_val1=8'h00, rx_msg_done=0, frame_err=0, err_count=0, timeout counter=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; no commit or error results.
REQ-028 Deassertion SHALL be synchronised to clk before use.

Configuration
REQ-029 Macro CMD_PARSER_TIMEOUT_EN: defined -> REQ-024/025 timeout logic compiled in.
REQ-030 Undefined -> no timeout counter; parser waits indefinitely in any state; TIMEOUT_CYCLES unused; all else identical.

Structure
REQ-031 Shared package cold_storage_pkg SHALL hold ASCII constants (cmd codes 'L','A'-'D', '0', '9', CR, LF), parser state typedef, default TIMEOUT_CYCLES.
REQ-032 One sub-module cmd_idle_timer (counter, restart input, expiry pulse output) SHALL implement the timeout, instantiated only under CMD_PARSER_TIMEOUT_EN.

Verification
REQ-033 Bytes 'A','1','8',LF -> chr_cmd=0x41, chr_val0=0x31, chr_val1=0x38, rx_msg_done=1 one cycle after LF strobe.
REQ-034 'D','3','x',CR -> frame_err one pulse on 'x', err_count=1, chr_* unchanged, state IDLE; CR ignored.
REQ-035 'B','4','C','2','5',CR -> error on 'C', resync, commit chr_cmd=0x43, val0=0x32, val1=0x35.
REQ-036 (timeout build, TIMEOUT_CYCLES=100) 'A','1', 150 idle cycles, '9',LF -> frame_err at cycle 100 after '1', '9' and LF ignored, no commit.
REQ-037 Commit 'L','1','0',CR, then 'C' -> rx_msg_done stays 1 through CR pair, clears one cycle after 'C' strobe; chr_* still 'L','1','0'.
REQ-038 260 bad frames then reset mid-frame ('A','2') -> err_count=255 before reset, all outputs 0 after, no commit.
